// File: rtl/fll_cfg_pkg.sv
// fll_cfg_pkg: shared constants for the FLL configuration responder.
// Register addresses, reset values, field positions and the handshake FSM states.
package fll_cfg_pkg;

   // Register addresses
   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_CFG1   = 2'd1;
   localparam logic [1:0] ADDR_CFG2   = 2'd2;
   localparam logic [1:0] ADDR_INTEG  = 2'd3;

   // Reset contents
   localparam logic [31:0] CFG1_RST   = 32'h0401_05F5;
   localparam logic [31:0] CFG2_RST   = 32'h0010_0107;
   // CFG2[15:12] is reserved: never stored, always reads 0
   localparam logic [31:0] CFG2_WMASK = 32'hFFFF_0FFF;

   // CFG1 fields
   localparam int MULT_LSB      = 0;
   localparam int MULT_W        = 16;
   localparam int DCO_LSB       = 16;
   localparam int DCO_W         = 10;
   localparam int DIV_LSB       = 26;
   localparam int DIV_W         = 4;
   localparam int OPEN_LOOP_BIT = 30;
   localparam int MODE_BIT      = 31;

   // CFG2 fields
   localparam int GAIN_LSB      = 0;
   localparam int GAIN_W        = 4;
   localparam int TOL_LSB       = 4;
   localparam int TOL_W         = 8;
   localparam int STABLE_LSB    = 16;

   // STATUS fields
   localparam int STAT_MEAS_W   = 16;
   localparam int STAT_LOCK_BIT = 16;

   // Handshake FSM
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_e;

endpackage

// File: rtl/fll_cfg_responder_lock_detect.sv
// fll_lock_detect: declares lock after STABLE consecutive in-tolerance period
// measurements; any out-of-tolerance measurement, open-loop mode or a clear
// request drops lock and restarts the count.
module fll_lock_detect
   import fll_cfg_pkg::*;
#(
   parameter int STABLE_W = 16
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic                meas_valid_i,
   input  logic [15:0]         meas_cnt_i,
   input  logic [15:0]         mult_i,
   input  logic [TOL_W-1:0]    tol_i,
   input  logic [STABLE_W-1:0] stable_i,
   input  logic                open_loop_i,
   input  logic                clear_i,
   output logic                lock_o
);

   logic [STABLE_W-1:0] cnt_q, cnt_d;
   logic                lock_q, lock_d;
   logic [16:0]         diff;
   logic [STABLE_W:0]   cnt_inc;
   logic [STABLE_W:0]   stable_eff;

   // Next counter/lock: clear and open-loop dominate, then measurement update
   always_comb begin
      cnt_d      = cnt_q;
      lock_d     = lock_q;
      cnt_inc    = {1'b0, cnt_q} + {{STABLE_W{1'b0}}, 1'b1};
      // A programmed STABLE of zero is treated as one
      stable_eff = (stable_i == '0) ? {{STABLE_W{1'b0}}, 1'b1} : {1'b0, stable_i};
      if (meas_cnt_i >= mult_i)
         diff = {1'b0, meas_cnt_i} - {1'b0, mult_i};
      else
         diff = {1'b0, mult_i} - {1'b0, meas_cnt_i};

      if (clear_i || open_loop_i) begin
         cnt_d  = '0;
         lock_d = 1'b0;
      end else if (meas_valid_i) begin
         if (diff <= {{(17-TOL_W){1'b0}}, tol_i}) begin
            // Saturate instead of wrapping so a long lock is never lost
            cnt_d  = cnt_inc[STABLE_W] ? cnt_q : cnt_inc[STABLE_W-1:0];
            lock_d = lock_q | (cnt_inc >= stable_eff);
         end else begin
            cnt_d  = '0;
            lock_d = 1'b0;
         end
      end
   end

   // Counter and lock state registers
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         cnt_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lock_q <= lock_d;
      end
   end

   assign lock_o = lock_q;

endmodule

// File: rtl/fll_cfg_responder.sv
// fll_cfg_responder: FLL-side end of the 4-phase req/ack config channel.
// Build option: define FLL_CFG_REQ_SYNC_EN to add a two-flop synchronizer on
// req_i (requester in another clock domain); otherwise req_i is used directly.
module fll_cfg_responder
   import fll_cfg_pkg::*;
#(
   parameter int STABLE_W = 16,
   parameter int INTEG_W  = 26
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic               req_i,
   input  logic               wrn_i,
   input  logic [1:0]         add_i,
   input  logic [31:0]        data_i,
   output logic               ack_o,
   output logic [31:0]        r_data_o,
   output logic               lock_o,
   input  logic               meas_valid_i,
   input  logic [15:0]        meas_cnt_i,
   output logic [31:0]        cfg1_o,
   output logic [31:0]        cfg2_o,
   output logic [INTEG_W-1:0] integ_o,
   output logic               integ_load_o
);

   logic req_s;

`ifdef FLL_CFG_REQ_SYNC_EN
   logic sync1_q, sync2_q;

   // Two-flop synchronizer for the asynchronous request level
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= req_i;
         sync2_q <= sync1_q;
      end
   end

   assign req_s = sync2_q;
`else
   assign req_s = req_i;
`endif

   state_e             state_q, state_d;
   logic               ack_q, ack_d;
   logic [31:0]        r_data_q, r_data_d;
   logic               integ_load_q, integ_load_d;
   logic [31:0]        cfg1_q, cfg1_d;
   logic [31:0]        cfg2_q, cfg2_d;
   logic [INTEG_W-1:0] integ_q, integ_d;
   logic [15:0]        meas_last_q, meas_last_d;
   logic [31:0]        rd_mux;
   logic [31:0]        integ_ext;
   logic               cfg_clear;
   logic               lock;

   // Read mux over the register values as they stand before this cycle's write
   always_comb begin
      integ_ext                = '0;
      integ_ext[INTEG_W-1:0]   = integ_q;
      rd_mux                   = '0;
      case (add_i)
         ADDR_STATUS: begin
            rd_mux[STAT_MEAS_W-1:0] = meas_last_q;
            rd_mux[STAT_LOCK_BIT]   = lock;
         end
         ADDR_CFG1:   rd_mux = cfg1_q;
         ADDR_CFG2:   rd_mux = cfg2_q;
         default:     rd_mux = integ_ext;
      endcase
   end

   // Handshake FSM and register-file next-state logic
   always_comb begin
      state_d      = state_q;
      r_data_d     = r_data_q;
      cfg1_d       = cfg1_q;
      cfg2_d       = cfg2_q;
      integ_d      = integ_q;
      integ_load_d = 1'b0;
      cfg_clear    = 1'b0;
      meas_last_d  = meas_valid_i ? meas_cnt_i : meas_last_q;

      case (state_q)
         ST_IDLE: begin
            if (req_s)
               state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            state_d = ST_ACK;
            if (wrn_i) begin
               r_data_d = rd_mux;
            end else begin
               case (add_i)
                  ADDR_CFG1: begin
                     cfg1_d    = data_i;
                     cfg_clear = 1'b1;
                  end
                  ADDR_CFG2: begin
                     cfg2_d    = data_i & CFG2_WMASK;
                     cfg_clear = 1'b1;
                  end
                  ADDR_INTEG: begin
                     integ_d      = data_i[INTEG_W-1:0];
                     integ_load_d = 1'b1;
                  end
                  default: ; // STATUS is read-only; the write is just acked
               endcase
            end
         end
         ST_ACK: begin
            if (!req_s)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      ack_d = (state_d == ST_ACK);
   end

   // FSM, handshake outputs and register file
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q      <= ST_IDLE;
         ack_q        <= 1'b0;
         r_data_q     <= '0;
         integ_load_q <= 1'b0;
         cfg1_q       <= CFG1_RST;
         cfg2_q       <= CFG2_RST;
         integ_q      <= '0;
         meas_last_q  <= '0;
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         r_data_q     <= r_data_d;
         integ_load_q <= integ_load_d;
         cfg1_q       <= cfg1_d;
         cfg2_q       <= cfg2_d;
         integ_q      <= integ_d;
         meas_last_q  <= meas_last_d;
      end
   end

   fll_lock_detect #(
      .STABLE_W (STABLE_W)
   ) u_lock_detect (
      .HCLK         (HCLK),
      .HRESET       (HRESET),
      .meas_valid_i (meas_valid_i),
      .meas_cnt_i   (meas_cnt_i),
      .mult_i       (cfg1_q[MULT_LSB +: MULT_W]),
      .tol_i        (cfg2_q[TOL_LSB +: TOL_W]),
      .stable_i     (cfg2_q[STABLE_LSB +: STABLE_W]),
      .open_loop_i  (cfg1_q[OPEN_LOOP_BIT]),
      .clear_i      (cfg_clear),
      .lock_o       (lock)
   );

   assign ack_o        = ack_q;
   assign r_data_o     = r_data_q;
   assign lock_o       = lock;
   assign cfg1_o       = cfg1_q;
   assign cfg2_o       = cfg2_q;
   assign integ_o      = integ_q;
   assign integ_load_o = integ_load_q;

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Testbench for fll_cfg_responder: scoreboard of expected read data checked by
// an ack monitor, plus a behavioural model of the registers and lock rules.
module tb_fll_cfg_responder;

   localparam int INTEG_W = 26;
`ifdef FLL_CFG_REQ_SYNC_EN
   localparam int LAT_UP = 4;
   localparam int LAT_DN = 3;
`else
   localparam int LAT_UP = 2;
   localparam int LAT_DN = 1;
`endif

   logic               HCLK = 1'b0;
   logic               HRESET = 1'b1;
   logic               req_i = 1'b0;
   logic               wrn_i = 1'b0;
   logic [1:0]         add_i = 2'd0;
   logic [31:0]        data_i = 32'd0;
   logic               ack_o;
   logic [31:0]        r_data_o;
   logic               lock_o;
   logic               meas_valid_i = 1'b0;
   logic [15:0]        meas_cnt_i = 16'd0;
   logic [31:0]        cfg1_o;
   logic [31:0]        cfg2_o;
   logic [INTEG_W-1:0] integ_o;
   logic               integ_load_o;

   fll_cfg_responder #(
      .STABLE_W (16),
      .INTEG_W  (INTEG_W)
   ) dut (
      .HCLK         (HCLK),
      .HRESET       (HRESET),
      .req_i        (req_i),
      .wrn_i        (wrn_i),
      .add_i        (add_i),
      .data_i       (data_i),
      .ack_o        (ack_o),
      .r_data_o     (r_data_o),
      .lock_o       (lock_o),
      .meas_valid_i (meas_valid_i),
      .meas_cnt_i   (meas_cnt_i),
      .cfg1_o       (cfg1_o),
      .cfg2_o       (cfg2_o),
      .integ_o      (integ_o),
      .integ_load_o (integ_load_o)
   );

   always #5 HCLK = ~HCLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] cfg1_m, cfg2_m, integ_m, last_rd_m;
   logic [15:0] meas_last_m;
   int          cnt_m;
   bit          lock_m;
   int          integ_writes_m;
   logic [31:0] exp_q[$];

   task automatic model_reset();
      cfg1_m      = 32'h0401_05F5;
      cfg2_m      = 32'h0010_0107;
      integ_m     = 32'd0;
      last_rd_m   = 32'd0;
      meas_last_m = 16'd0;
      cnt_m       = 0;
      lock_m      = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return {15'd0, lock_m, meas_last_m};
         2'd1:    return cfg1_m;
         2'd2:    return cfg2_m;
         default: return integ_m;
      endcase
   endfunction

   task automatic model_write(input logic [1:0] a, input logic [31:0] d);
      case (a)
         2'd1: begin cfg1_m = d; cnt_m = 0; lock_m = 1'b0; end
         2'd2: begin cfg2_m = {d[31:16], 4'h0, d[11:0]}; cnt_m = 0; lock_m = 1'b0; end
         2'd3: begin integ_m = d & ((32'd1 << INTEG_W) - 32'd1); integ_writes_m++; end
         default: ;
      endcase
   endtask

   task automatic model_meas(input logic [15:0] c);
      int mult, tol, st, diff;
      meas_last_m = c;
      mult = int'(cfg1_m[15:0]);
      tol  = int'(cfg2_m[11:4]);
      st   = int'(cfg2_m[31:16]);
      if (st == 0) st = 1;
      if (cfg1_m[30]) begin
         cnt_m = 0; lock_m = 1'b0;
      end else begin
         diff = (int'(c) > mult) ? int'(c) - mult : mult - int'(c);
         if (diff <= tol) begin
            if (cnt_m + 1 >= st) lock_m = 1'b1;
            if (cnt_m < 65535) cnt_m = cnt_m + 1;
         end else begin
            cnt_m = 0; lock_m = 1'b0;
         end
      end
   endtask

   // Model-side effect of issuing a transaction; pushes the r_data_o expected at ack
   task automatic model_txn(input bit rd, input logic [1:0] a, input logic [31:0] d);
      if (rd) last_rd_m = model_read(a);
      else    model_write(a, d);
      exp_q.push_back(last_rd_m);
   endtask

   // ---------------- monitors ----------------
   int integ_pulses = 0;

   initial begin : ack_monitor
      bit ack_prev = 1'b0;
      logic [31:0] exp;
      forever begin
         @(negedge HCLK);
         if (ack_o && !ack_prev) begin
            if (exp_q.size() == 0) begin
               check("ack_unexpected", 32'd1, 32'd0);
            end else begin
               exp = exp_q.pop_front();
               check("r_data_at_ack", r_data_o, exp);
            end
         end
         ack_prev = ack_o;
      end
   end

   initial begin : load_monitor
      bit load_prev = 1'b0;
      forever begin
         @(negedge HCLK);
         if (integ_load_o) begin
            integ_pulses++;
            check("integ_load_width", {31'd0, load_prev}, 32'd0);
         end
         load_prev = integ_load_o;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ack(input bit level, output int edges);
      edges = 0;
      while (ack_o !== level && edges < 20) begin
         @(posedge HCLK);
         edges++;
         @(negedge HCLK);
      end
   endtask

   // Full 4-phase transaction; optionally injects a measurement strobe in the ACCESS cycle
   task automatic do_txn(input bit rd, input logic [1:0] a, input logic [31:0] d,
                         input bit inj, input logic [15:0] inj_cnt);
      int edges;
      model_txn(rd, a, d);
      if (inj) meas_last_m = inj_cnt;   // the clear from the write wins over the count
      @(negedge HCLK);
      wrn_i  = rd;
      add_i  = a;
      data_i = d;
      req_i  = 1'b1;
      edges  = 0;
      while (ack_o !== 1'b1 && edges < 20) begin
         if (inj && edges == LAT_UP - 1) begin
            meas_valid_i = 1'b1;
            meas_cnt_i   = inj_cnt;
         end
         @(posedge HCLK);
         edges++;
         @(negedge HCLK);
         meas_valid_i = 1'b0;
      end
      check("ack_rise_latency", edges, LAT_UP);
      req_i = 1'b0;
      wait_ack(1'b0, edges);
      check("ack_fall_latency", edges, LAT_DN);
      data_i = $urandom;
      check("cfg1_o", cfg1_o, cfg1_m);
      check("cfg2_o", cfg2_o, cfg2_m);
      check("integ_o", {{(32-INTEG_W){1'b0}}, integ_o}, integ_m);
   endtask

   task automatic send_meas(input logic [15:0] c);
      @(negedge HCLK);
      meas_valid_i = 1'b1;
      meas_cnt_i   = c;
      model_meas(c);
      @(negedge HCLK);
      meas_valid_i = 1'b0;
      check("lock_o", {31'd0, lock_o}, {31'd0, lock_m});
   endtask

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int edges;
      int pulses_before;
      logic [31:0] d;
      logic [1:0]  a;
      logic [15:0] c;
      bit rd;

      integ_writes_m = 0;
      model_reset();
      repeat (3) @(negedge HCLK);
      HRESET = 1'b0;

      check("rst_ack", {31'd0, ack_o}, 32'd0);
      check("rst_r_data", r_data_o, 32'd0);
      check("rst_lock", {31'd0, lock_o}, 32'd0);
      check("rst_integ_load", {31'd0, integ_load_o}, 32'd0);
      check("rst_integ", {{(32-INTEG_W){1'b0}}, integ_o}, 32'd0);
      check("rst_cfg1", cfg1_o, 32'h0401_05F5);
      check("rst_cfg2", cfg2_o, 32'h0010_0107);

      // Directed register accesses
      do_txn(1'b1, 2'd1, 32'd0, 1'b0, 16'd0);
      do_txn(1'b0, 2'd2, 32'hFFFF_FFFF, 1'b0, 16'd0);
      do_txn(1'b1, 2'd2, 32'd0, 1'b0, 16'd0);
      pulses_before = integ_pulses;
      do_txn(1'b0, 2'd3, 32'h0123_4567, 1'b0, 16'd0);
      check("integ_pulse_count", integ_pulses - pulses_before, 32'd1);
      do_txn(1'b1, 2'd3, 32'd0, 1'b0, 16'd0);
      do_txn(1'b0, 2'd0, 32'hDEAD_BEEF, 1'b0, 16'd0);

      // Lock detection: TOL 16, STABLE 4
      do_txn(1'b0, 2'd2, 32'h0004_0107, 1'b0, 16'd0);
      repeat (4) send_meas(16'h0600);
      send_meas(16'h0610);
      do_txn(1'b1, 2'd0, 32'd0, 1'b0, 16'd0);

      // CFG1 write colliding with an in-tolerance measurement
      repeat (4) send_meas(16'h0600);
      do_txn(1'b0, 2'd1, 32'h0401_05F5, 1'b1, 16'h0600);
      check("lock_after_cfg_clear", {31'd0, lock_o}, 32'd0);
      repeat (4) send_meas(16'h0600);
      do_txn(1'b1, 2'd0, 32'd0, 1'b0, 16'd0);

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            c = cfg1_m[15:0] + 16'($urandom_range(0, 40)) - 16'd20;
            send_meas(c);
         end else begin
            rd = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            d  = $urandom;
            if (a == 2'd2) d[31:16] = 16'($urandom_range(0, 5));
            if (a == 2'd1) d[30] = ($urandom_range(0, 3) == 0);
            do_txn(rd, a, d, 1'b0, 16'd0);
         end
      end

      // Reset while acking an INTEG write with req_i still high
      pulses_before = integ_pulses;
      d = 32'h00AB_CDEF;
      model_txn(1'b0, 2'd3, d);
      @(negedge HCLK);
      wrn_i = 1'b0; add_i = 2'd3; data_i = d; req_i = 1'b1;
      wait_ack(1'b1, edges);
      check("pre_reset_ack_latency", edges, LAT_UP);
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      check("mid_reset_ack", {31'd0, ack_o}, 32'd0);
      check("mid_reset_integ", {{(32-INTEG_W){1'b0}}, integ_o}, 32'd0);
      model_reset();
      model_txn(1'b0, 2'd3, d);
      wait_ack(1'b1, edges);
      check("reexec_ack_latency", edges, LAT_UP);
      req_i = 1'b0;
      wait_ack(1'b0, edges);
      check("reexec_ack_fall", edges, LAT_DN);
      check("reexec_integ", {{(32-INTEG_W){1'b0}}, integ_o}, integ_m);
      check("reexec_cfg1", cfg1_o, 32'h0401_05F5);
      check("reexec_integ_pulses", integ_pulses - pulses_before, 32'd2);

      repeat (4) @(negedge HCLK);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      check("integ_pulses_total", integ_pulses, integ_writes_m);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
